// File: rtl/lsu_mem_if.sv
// Consumer-side bundle between a load/store unit and the memory controller:
// one read and one write request/ready channel.
interface lsu_mem_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16
);
  logic                 mem_read_request;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;
  logic                 mem_write_request;
  logic [ADDR_BITS-1:0] mem_write_address;
  logic [DATA_BITS-1:0] mem_write_data;
  logic                 mem_write_ready;

  modport master (
    output mem_read_request, mem_read_address,
    input  mem_read_ready, mem_read_data,
    output mem_write_request, mem_write_address, mem_write_data,
    input  mem_write_ready
  );

  modport slave (
    input  mem_read_request, mem_read_address,
    output mem_read_ready, mem_read_data,
    input  mem_write_request, mem_write_address, mem_write_data,
    output mem_write_ready
  );
endinterface

// File: rtl/load_store_unit.sv
// Per-thread load/store unit: one LDR/STR becomes one request/ready memory transaction.
// Optional LSU_TIMEOUT_EN adds a wait timeout with a sticky lsu_error flag.
module load_store_unit #(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 decoded_mem_read_enable,
  input  logic                 decoded_mem_write_enable,
  input  logic [DATA_BITS-1:0] rs,
  input  logic [DATA_BITS-1:0] rt,
  lsu_mem_if.master            mem,
  output logic [1:0]           lsu_state,
  output logic [DATA_BITS-1:0] lsu_out,
  output logic                 lsu_error
);
  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;

  typedef enum logic [1:0] {IDLE = 2'd0, REQUESTING = 2'd1, WAITING = 2'd2, DONE = 2'd3} state_t;

  state_t               state_reg, state_next;
  logic                 is_read_reg, is_read_next;
  logic                 read_req_reg, read_req_next;
  logic [ADDR_BITS-1:0] read_addr_reg, read_addr_next;
  logic                 write_req_reg, write_req_next;
  logic [ADDR_BITS-1:0] write_addr_reg, write_addr_next;
  logic [DATA_BITS-1:0] write_data_reg, write_data_next;
  logic [DATA_BITS-1:0] out_reg, out_next;

  logic start_read, start_write, active_ready, timeout_hit;
  logic unused_rs_hi;

  // A still-high ready from the previous transaction blocks issue, so it is never mistaken for a reply.
  assign start_read   = enable && (core_state == CORE_REQUEST) && decoded_mem_read_enable && !mem.mem_read_ready;
  assign start_write  = enable && (core_state == CORE_REQUEST) && !decoded_mem_read_enable &&
                        decoded_mem_write_enable && !mem.mem_write_ready;
  assign active_ready = is_read_reg ? mem.mem_read_ready : mem.mem_write_ready;
  assign unused_rs_hi = ^rs[DATA_BITS-1:ADDR_BITS];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      is_read_reg    <= 1'b0;
      read_req_reg   <= 1'b0;
      read_addr_reg  <= '0;
      write_req_reg  <= 1'b0;
      write_addr_reg <= '0;
      write_data_reg <= '0;
      out_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      is_read_reg    <= is_read_next;
      read_req_reg   <= read_req_next;
      read_addr_reg  <= read_addr_next;
      write_req_reg  <= write_req_next;
      write_addr_reg <= write_addr_next;
      write_data_reg <= write_data_next;
      out_reg        <= out_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:       if (start_read || start_write) state_next = REQUESTING;
      REQUESTING: state_next = WAITING;
      WAITING:    if (active_ready || timeout_hit) state_next = DONE;
      DONE:       if (core_state == CORE_UPDATE) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    is_read_next    = is_read_reg;
    read_req_next   = read_req_reg;
    read_addr_next  = read_addr_reg;
    write_req_next  = write_req_reg;
    write_addr_next = write_addr_reg;
    write_data_next = write_data_reg;
    out_next        = out_reg;
    case (state_reg)
      IDLE: begin
        if (start_read) begin
          is_read_next   = 1'b1;
          read_addr_next = rs[ADDR_BITS-1:0];
        end else if (start_write) begin
          is_read_next    = 1'b0;
          write_addr_next = rs[ADDR_BITS-1:0];
          write_data_next = rt;
        end
      end
      REQUESTING: begin
        read_req_next  = is_read_reg;
        write_req_next = !is_read_reg;
      end
      WAITING: begin
        if (active_ready || timeout_hit) begin
          read_req_next  = 1'b0;
          write_req_next = 1'b0;
        end
        if (active_ready && is_read_reg) out_next = mem.mem_read_data;
      end
      default: ;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_BITS = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_BITS-1:0] cnt_reg, cnt_next;
  logic                error_reg, error_next;

  // The cycle that would bring the count to TIMEOUT_CYCLES is the one that gives up.
  assign timeout_hit = (state_reg == WAITING) && !active_ready &&
                       (cnt_reg == CNT_BITS'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_next   = cnt_reg;
    error_next = error_reg || timeout_hit;
    if (state_reg == REQUESTING) cnt_next = '0;
    else if (state_reg == WAITING && !active_ready) cnt_next = cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg   <= '0;
      error_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      error_reg <= error_next;
    end
  end

  assign lsu_error = error_reg;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
  assign lsu_error          = 1'b0;
`endif

  assign lsu_state             = state_reg;
  assign lsu_out               = out_reg;
  assign mem.mem_read_request  = read_req_reg;
  assign mem.mem_read_address  = read_addr_reg;
  assign mem.mem_write_request = write_req_reg;
  assign mem.mem_write_address = write_addr_reg;
  assign mem.mem_write_data    = write_data_reg;
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Per-thread load/store unit. Sits directly upstream of the memory controller, as one of its NUM_CONSUMERS consumers.
- Turns a decoded LDR/STR into one request/ready transaction on the controller's consumer read or write port. Holds the loaded word for register writeback.
- Sequenced by the core's state so each instruction issues exactly one memory access.

Parameters:
ADDR_BITS, 8, memory address width (matches controller)
DATA_BITS, 16, data word width (matches controller)
TIMEOUT_CYCLES, 255, max cycles to wait for ready (used only with LSU_TIMEOUT_EN)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
enable  input  1  thread active; when 0 the unit stays IDLE and ignores decode
core_state  input  3  core phase: REQUEST=3'b011, WAIT=3'b100, UPDATE=3'b110, others ignored
decoded_mem_read_enable  input  1  current instruction is LDR
decoded_mem_write_enable  input  1  current instruction is STR
rs  input  DATA_BITS  address operand; address = rs[ADDR_BITS-1:0]
rt  input  DATA_BITS  store data
mem_read_request  output  1  to controller consumer_read_request[k]
mem_read_address  output  ADDR_BITS  to consumer_read_address[k]
mem_read_ready  input  1  from consumer_read_ready[k]
mem_read_data  input  DATA_BITS  from consumer_read_data[k]
mem_write_request  output  1  to consumer_write_request[k]
mem_write_address  output  ADDR_BITS  to consumer_write_address[k]
mem_write_data  output  DATA_BITS  to consumer_write_data[k]
mem_write_ready  input  1  from consumer_write_ready[k]
lsu_state  output  2  IDLE=0, REQUESTING=1, WAITING=2, DONE=3; the core stalls in WAIT until DONE
lsu_out  output  DATA_BITS  last loaded word
lsu_error  output  1  sticky timeout flag (LSU_TIMEOUT_EN only, else tied 0)

Behaviour:
- All outputs are registered. Reset (sync, active-high, overrides everything, including mid-transaction) clears all outputs to 0 and sets lsu_state to IDLE.
- IDLE:
  - Leave IDLE only when enable=1, core_state==REQUEST, and the matching ready input is 0. The ready check is a guard against the controller's ready of a prior transaction that has not yet cleared.
  - If read_enable=1: go to REQUESTING and latch mem_read_address=rs[ADDR_BITS-1:0].
  - Else if write_enable=1: go to REQUESTING and latch mem_write_address and mem_write_data=rt.
  - Read wins if both enables are set; no write is issued in that case.
  - If neither enable is set, remain IDLE.
- REQUESTING (1 cycle): assert the matching request. Go to WAITING. Address and data stay stable until the request drops.
- WAITING:
  - Hold the request until the matching ready=1.
  - On that cycle: deassert the request, capture lsu_out<=mem_read_data (reads only), go to DONE.
  - Ready on the non-requested port is ignored.
- DONE: hold lsu_out. Go to IDLE when core_state==UPDATE.
- Latency: request high 1 cycle after the REQUEST edge. DONE 1 cycle after ready is sampled high.
- Controller interplay: the controller clears ready one cycle after it sees the request low. IDLE's ready-low guard prevents a back-to-back request from being misread as already served.
- Changing enable or decode in any state other than IDLE has no effect.
- lsu_out is unchanged by writes.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on entry to WAITING and increments each cycle ready is low.
  - When the count reaches TIMEOUT_CYCLES: deassert the request, set lsu_error=1 (sticky until reset), go to DONE with lsu_out unchanged.
  - A late ready is absorbed by the IDLE guard.
- Undefined: no counter; WAITING waits indefinitely; lsu_error is constant 0.

Test Plan:
- Load: rs=0x0012, read_enable, core_state=REQUEST; memory returns 0xBEEF with ready 3 cycles later -> mem_read_address=0x12, request high 3 cycles; lsu_out=0xBEEF; lsu_state=DONE; IDLE after UPDATE.
- Store: rs=0x0040, rt=0x1234, write_enable -> mem_write_address=0x40, mem_write_data=0x1234 held until write ready; lsu_out unchanged; DONE.
- Back-to-back: second load issued while the previous read_ready is still 1 -> no new request until ready=0, then correct address and data.
- Both enables set, rs=0x05 -> only mem_read_request asserted; mem_write_request stays 0.
- Reset asserted in WAITING with request high -> next cycle request=0, lsu_state=IDLE, lsu_out=0.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=10, ready never asserted -> request drops after 10 waiting cycles, lsu_error=1, DONE; error stays 1 through the next successful load.
